// File: rtl/collision_scheduler.sv
// ----------------------------------------------------------------------------
// collision_scheduler
//   Frame-synchronous sequencer around one shared rectangle-vs-wall overlap
//   comparator. A rising edge on frame_clk takes a snapshot of all tank,
//   bullet and wall positions. The scheduler then walks 4 objects x 4 walls,
//   one comparison per Clk, and publishes registered can_move/hit results.
//
// Ports
//   Clk, Reset                  system clock, async active-high reset
//   frame_clk                   frame tick (async to Clk), rising edge starts a pass
//   X1..X4, Y1..Y4              wall top-left corners (walls 1,3 horizontal; 2,4 vertical)
//   X/Y_Tank1/2, X/Y_Bullet1/2  object top-left corners
//   tank_dir1/2, bullet_dir1/2  1 up, 2 right, 3 left, 4 down, else stationary
//   can_move1/2                 1 = tank may take its step this frame
//   hit1/2                      2'b00 = bullet hits a wall, 2'b01 = clear
//   busy                        pass in progress (LOAD or CHECK)
//   results_valid               one-Clk pulse when the outputs update
//   overrun                     one-Clk pulse when a frame edge arrives while busy
//
// State  | meaning
// IDLE   | waiting for a synchronized frame edge
// LOAD   | snapshot inputs, clear accumulators
// CHECK  | 16 comparisons, object-major (tank1, tank2, bullet1, bullet2)
// DONE   | results published, results_valid high
// ----------------------------------------------------------------------------
module collision_scheduler #(
    parameter logic [9:0]  TANK_SIZE   = 10'd32,
    parameter logic [9:0]  BULLET_SIZE = 10'd8,
    parameter logic [9:0]  TANK_STEP   = 10'd1,
    parameter logic [9:0]  BULLET_STEP = 10'd5,
    parameter logic [10:0] H_W         = 11'd64,
    parameter logic [10:0] H_H         = 11'd32,
    parameter logic [10:0] V_W         = 11'd32,
    parameter logic [10:0] V_H         = 11'd64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] X1,
    input  logic [9:0] Y1,
    input  logic [9:0] X2,
    input  logic [9:0] Y2,
    input  logic [9:0] X3,
    input  logic [9:0] Y3,
    input  logic [9:0] X4,
    input  logic [9:0] Y4,
    input  logic [9:0] X_Tank1,
    input  logic [9:0] Y_Tank1,
    input  logic [9:0] X_Tank2,
    input  logic [9:0] Y_Tank2,
    input  logic [9:0] X_Bullet1,
    input  logic [9:0] Y_Bullet1,
    input  logic [9:0] X_Bullet2,
    input  logic [9:0] Y_Bullet2,
    input  logic [2:0] tank_dir1,
    input  logic [2:0] tank_dir2,
    input  logic [2:0] bullet_dir1,
    input  logic [2:0] bullet_dir2,
    output logic       can_move1,
    output logic       can_move2,
    output logic [1:0] hit1,
    output logic [1:0] hit2,
    output logic       busy,
    output logic       results_valid,
    output logic       overrun
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_fsync1;
    logic        r_fsync2;
    logic        r_fprev;
    logic        w_start;
    logic        w_busy;

    logic [1:0]  r_obj;
    logic [1:0]  r_wall;
    logic [3:0]  r_blocked;
    logic [3:0]  w_blocked_next;
    logic        w_last;

    logic [9:0]  r_ox [0:3];
    logic [9:0]  r_oy [0:3];
    logic [2:0]  r_od [0:3];
    logic [9:0]  r_wx [0:3];
    logic [9:0]  r_wy [0:3];

    logic        r_can_move1;
    logic        r_can_move2;
    logic [1:0]  r_hit1;
    logic [1:0]  r_hit2;
    logic        r_results_valid;

    logic [10:0] w_x, w_y, w_cx, w_cy, w_s, w_p;
    logic [10:0] w_wx, w_wy, w_ww, w_wh;
    logic        w_under;
    logic        w_moving;
    logic        w_overlap;

    // frame_clk synchronizer and edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fprev  <= 1'b0;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fprev  <= r_fsync2;
        end
    end

    assign w_start = r_fsync2 & ~r_fprev;
    assign w_busy  = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_last  = (r_obj == 2'd3) && (r_wall == 2'd3);

    // FSM state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_CHECK;
            S_CHECK: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shared comparator: candidate box of the current object vs current wall
    always_comb begin
        w_x      = {1'b0, r_ox[r_obj]};
        w_y      = {1'b0, r_oy[r_obj]};
        w_s      = r_obj[1] ? {1'b0, BULLET_SIZE} : {1'b0, TANK_SIZE};
        w_p      = r_obj[1] ? {1'b0, BULLET_STEP} : {1'b0, TANK_STEP};
        w_wx     = {1'b0, r_wx[r_wall]};
        w_wy     = {1'b0, r_wy[r_wall]};
        // wall index 0/2 are walls 1/3 (horizontal), 1/3 are walls 2/4 (vertical)
        w_ww     = r_wall[0] ? V_W : H_W;
        w_wh     = r_wall[0] ? V_H : H_H;
        w_cx     = w_x;
        w_cy     = w_y;
        w_under  = 1'b0;
        w_moving = 1'b1;
        case (r_od[r_obj])
            3'd1: begin
                w_under = (w_y < w_p);
                w_cy    = w_y - w_p;
            end
            3'd2: w_cx = w_x + w_p;
            3'd3: begin
                w_under = (w_x < w_p);
                w_cx    = w_x - w_p;
            end
            3'd4: w_cy = w_y + w_p;
            default: w_moving = 1'b0;
        endcase
        // stepping off the top/left edge counts as blocked regardless of the wall
        w_overlap = w_moving & (w_under |
                    ((w_cx < w_wx + w_ww) && (w_cx + w_s > w_wx) &&
                     (w_cy < w_wy + w_wh) && (w_cy + w_s > w_wy)));
    end

    always_comb begin
        w_blocked_next        = r_blocked;
        w_blocked_next[r_obj] = r_blocked[r_obj] | w_overlap;
    end

    // Snapshot, walk counters, accumulators and published results
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_obj           <= 2'd0;
            r_wall          <= 2'd0;
            r_blocked       <= 4'd0;
            r_can_move1     <= 1'b1;
            r_can_move2     <= 1'b1;
            r_hit1          <= 2'b01;
            r_hit2          <= 2'b01;
            r_results_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_ox[i] <= 10'd0;
                r_oy[i] <= 10'd0;
                r_od[i] <= 3'd0;
                r_wx[i] <= 10'd0;
                r_wy[i] <= 10'd0;
            end
        end else begin
            r_results_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_ox[0] <= X_Tank1;   r_oy[0] <= Y_Tank1;   r_od[0] <= tank_dir1;
                    r_ox[1] <= X_Tank2;   r_oy[1] <= Y_Tank2;   r_od[1] <= tank_dir2;
                    r_ox[2] <= X_Bullet1; r_oy[2] <= Y_Bullet1; r_od[2] <= bullet_dir1;
                    r_ox[3] <= X_Bullet2; r_oy[3] <= Y_Bullet2; r_od[3] <= bullet_dir2;
                    r_wx[0] <= X1; r_wy[0] <= Y1;
                    r_wx[1] <= X2; r_wy[1] <= Y2;
                    r_wx[2] <= X3; r_wy[2] <= Y3;
                    r_wx[3] <= X4; r_wy[3] <= Y4;
                    r_blocked <= 4'd0;
                    r_obj     <= 2'd0;
                    r_wall    <= 2'd0;
                end
                S_CHECK: begin
                    r_blocked <= w_blocked_next;
                    r_wall    <= r_wall + 2'd1;
                    if (r_wall == 2'd3) r_obj <= r_obj + 2'd1;
                    // publish on the edge entering DONE, including the final comparison
                    if (w_last) begin
                        r_can_move1     <= ~w_blocked_next[0];
                        r_can_move2     <= ~w_blocked_next[1];
                        r_hit1          <= w_blocked_next[2] ? 2'b00 : 2'b01;
                        r_hit2          <= w_blocked_next[3] ? 2'b00 : 2'b01;
                        r_results_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign can_move1     = r_can_move1;
    assign can_move2     = r_can_move2;
    assign hit1          = r_hit1;
    assign hit2          = r_hit2;
    assign results_valid = r_results_valid;
    assign busy          = w_busy;
    assign overrun       = w_start & w_busy;

endmodule
